// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// addresses, STATUS bit layout, control-bit positions and the FSM state type.
package uart_pkg;

  localparam logic [31:0] DATA_ADDR   = 32'hFFFF_0010;
  localparam logic [31:0] STATUS_ADDR = 32'hFFFF_0014;

  localparam int STAT_FULL     = 0;
  localparam int STAT_EMPTY    = 1;
  localparam int STAT_BUSY     = 2;
  localparam int STAT_OVERFLOW = 3;
  localparam int STAT_IRQ      = 4;

  // Bits of a store to STATUS that clear the sticky flags.
  localparam int CLR_IRQ_BIT = 0;
  localparam int CLR_OVF_BIT = 3;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with an occupancy counter; pointers wrap modulo DEPTH
// (DEPTH must be a power of two). A pop on a full FIFO frees a slot for a same-cycle push.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; occupancy alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a transmit FIFO, STATUS register and
// optional completion interrupt (enabled by defining UART_TX_IRQ_EN).
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data,
  input  logic [31:0] address,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] rdata,
  output logic        UartAddress,
  output logic        TxInterrupt,
  output logic        tx
);

  localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

  tx_state_t     r_state;
  logic [15:0]   r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_overflow;

  logic          w_hit_data;
  logic          w_hit_status;
  logic          w_data_store;
  logic          w_status_store;
  logic          w_baud_end;
  logic          w_stop_end;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [7:0]    w_head;
  logic [CW-1:0] w_count;
  logic          w_irq;
  logic [31:0]   w_status;
  logic          w_unused;

  assign w_hit_data     = (address == DATA_ADDR);
  assign w_hit_status   = (address == STATUS_ADDR);
  assign w_data_store   = MemWrite && w_hit_data;
  assign w_status_store = MemWrite && w_hit_status;
  assign w_baud_end     = (r_baud == BAUD_MAX);
  assign w_stop_end     = (r_state == STOP) && w_baud_end;
  // The head is taken when idle, or at the end of STOP so frames run back to back.
  assign w_pop          = !w_empty && ((r_state == IDLE) || w_stop_end);

  uart_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_data_store),
    .i_data  (data[7:0]),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_shift <= w_head;
            r_baud  <= '0;
            r_tx    <= 1'b0;
            r_state <= START;
          end
        end
        START: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_state <= DATA;
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        DATA: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        STOP: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (!w_empty) begin
              r_shift <= w_head;
              r_tx    <= 1'b0;
              r_state <= START;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A store that finds the FIFO full is dropped, unless a dequeue happens in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (w_data_store && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end else if (w_status_store && data[CLR_OVF_BIT]) begin
      r_overflow <= 1'b0;
    end
  end

`ifdef UART_TX_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_irq <= 1'b0;
    end else if (w_stop_end && w_empty) begin
      r_irq <= 1'b1;
    end else if (w_status_store && data[CLR_IRQ_BIT]) begin
      r_irq <= 1'b0;
    end
  end

  assign w_irq = r_irq;
`else
  assign w_irq = 1'b0;
`endif

  // NOTE: default every always_comb output first so no path can infer a latch.
  always_comb begin
    w_status                = '0;
    w_status[STAT_FULL]     = w_full;
    w_status[STAT_EMPTY]    = w_empty;
    w_status[STAT_BUSY]     = (r_state != IDLE);
    w_status[STAT_OVERFLOW] = r_overflow;
    w_status[STAT_IRQ]      = w_irq;
  end

  assign rdata       = (MemRead && w_hit_status) ? w_status : 32'h0;
  assign UartAddress = w_hit_data || w_hit_status;
  assign TxInterrupt = w_irq;
  assign tx          = r_tx;
  assign w_unused    = ^{data[31:8], w_count};

endmodule

// File: doc/uart_tx_mmio.md
UART_TX_MMIO -- requirements
Module: uart_tx_mmio

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, transmit FIFO entries; power of two, at least 2.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port data  input  32  store data from the core register file (rt operand).
REQ-006 Port address  input  32  effective address from the core ALU.
REQ-007 Port MemRead  input  1  load strobe from the decoder.
REQ-008 Port MemWrite  input  1  store strobe from the decoder.
REQ-009 Port rdata  output  32  load data for the write-back path.
REQ-010 Port UartAddress  output  1  address hit; the core uses it to suppress data-memory access.
REQ-011 Port TxInterrupt  output  1  level interrupt request to cp0.
REQ-012 Port tx  output  1  serial line; idle high.

Function
REQ-013 DATA register at 0xFFFF0010; a store with a non-full FIFO enqueues data[7:0] at the clock edge; data[31:8] is ignored.
REQ-014 STATUS register at 0xFFFF0014; read value = {27'b0, irq, overflow, busy, empty, full} (bits 4..0).
REQ-015 UartAddress = 1 combinationally whenever address equals either register, independent of MemRead/MemWrite.
REQ-016 rdata = STATUS when MemRead and address is STATUS; otherwise 0; DATA reads return 0.
REQ-017 A store to a full FIFO is dropped and sets sticky overflow; a same-cycle dequeue frees a slot, so the store is accepted.
REQ-018 A store to STATUS with data[0]=1 clears irq; with data[3]=1, it clears overflow; other bits are ignored.
REQ-019 The FSM has states IDLE, START, DATA, STOP; the reset state is IDLE.
REQ-020 IDLE with FIFO non-empty: dequeue the head into the shift register, go to START at the next edge; tx = 0 from that edge.
REQ-021 START, each DATA bit (LSB first, 8 bits) and STOP (tx = 1) each last exactly CLKS_PER_BIT cycles; the baud counter wraps from CLKS_PER_BIT-1 to 0.
REQ-022 The frame is 10*CLKS_PER_BIT cycles; at STOP end, the FSM goes to START directly if the FIFO is non-empty, else to IDLE; there is no idle gap between back-to-back frames.
REQ-023 busy = 1 in every state other than IDLE.
REQ-024 irq sets when STOP ends with the FIFO empty; a simultaneous set and software clear resolves to set.
REQ-025 Full and empty are derived from an occupancy count of width clog2(FIFO_DEPTH)+1; the pointers wrap modulo FIFO_DEPTH.

Reset
REQ-026 Reset asserted: FSM = IDLE, FIFO empty, counters = 0, irq = 0, overflow = 0, tx = 1, TxInterrupt = 0; reset mid-frame aborts the frame immediately.
REQ-027 After deassertion, the first transmit begins only after a new store.

Configuration
REQ-028 Macro UART_TX_IRQ_EN defined: TxInterrupt = irq.
REQ-029 Macro UART_TX_IRQ_EN undefined: TxInterrupt is tied to 0, the irq flop is removed and STATUS bit 4 reads 0; all other behaviour is unchanged.

Structure
REQ-030 Shared package uart_pkg holds the DATA/STATUS address constants, STATUS bit indices and the FSM state typedef.
REQ-031 The FIFO is the sub-module uart_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count).

Verification
REQ-032 CLKS_PER_BIT=4; store 0xA5 to 0xFFFF0010 -> tx low for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles; busy is 1 for all 40 cycles.
REQ-033 Five stores with FIFO_DEPTH=4 and the FSM idle -> the first is dequeued at once, the other four fill the FIFO; a sixth store -> full=1, overflow=1, byte dropped.
REQ-034 Two stores back-to-back -> frames are contiguous (80 cycles at CLKS_PER_BIT=4); irq=1 after the second STOP; storing 0x1 to 0xFFFF0014 -> irq=0.
REQ-035 Reset pulled low during DATA bit 3 -> the same cycle gives tx=1, STATUS reads 0x2.
REQ-036 Load from 0xFFFF0014 -> UartAddress=1 and rdata = STATUS; load from 0x10000000 -> UartAddress=0, rdata=0.
REQ-037 Build without UART_TX_IRQ_EN, run REQ-034 stimulus -> TxInterrupt stays 0 and STATUS bit 4 reads 0.
